// File: rtl/seg_scan_mux.sv
// Time-multiplexed BCD digit scanner with per-slot ghost-blanking guard and per-frame input latch.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_mux #(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned CLK_DIV     = 50000,
   parameter int unsigned BLANK_CYC   = 500,
   parameter bit          SEL_ACT_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [4*DIGITS-1:0] bcd_in,
   input  logic [DIGITS-1:0]   dp_in,
   output logic [3:0]          bcd_out,
   output logic [DIGITS-1:0]   dig_sel,
   output logic                dp_n,
   output logic                frame_tick
);

   localparam int unsigned       CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned       IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0]     CNT_MAX = CW'(CLK_DIV - 1);
   localparam logic [IW-1:0]     IDX_MAX = IW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{SEL_ACT_LOW}};

   logic [CW-1:0]       cnt;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] shadow;
   logic [DIGITS-1:0]   shdp;

   logic                slot_end;
   logic                frame_end;
   logic                guard_ok;
   logic                lz_blank;
   logic [3:0]          cur_bcd;
   logic                cur_dp;
   logic [DIGITS-1:0]   sel_act;

   assign slot_end  = (cnt == CNT_MAX);
   assign frame_end = slot_end && (idx == IDX_MAX);

   generate
      if (BLANK_CYC == 0) begin : g_noguard
         assign guard_ok = 1'b1;
      end else begin : g_guard
         assign guard_ok = (cnt >= CW'(BLANK_CYC));
      end
   endgenerate

   always_comb begin
      cur_bcd = '0;
      cur_dp  = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_bcd = shadow[4*i +: 4];
            cur_dp  = shdp[i];
         end
      end
   end

`ifdef SEG_SCAN_LZ_BLANK_EN
   logic zero_above;

   // Walk from the most significant digit down; digit 0 is never visited so it is never blanked.
   always_comb begin
      lz_blank   = 1'b0;
      zero_above = 1'b1;
      for (int unsigned k = 0; k + 1 < DIGITS; k++) begin
         zero_above = zero_above & (shadow[4*(DIGITS-1-k) +: 4] == 4'd0) & ~shdp[DIGITS-1-k];
         if ((idx == IW'(DIGITS-1-k)) && zero_above)
            lz_blank = 1'b1;
      end
   end
`else
   assign lz_blank = 1'b0;
`endif

   always_comb begin
      sel_act = '0;
      if (guard_ok && !lz_blank) begin
         for (int unsigned i = 0; i < DIGITS; i++)
            sel_act[i] = (idx == IW'(i));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         shadow     <= '0;
         shdp       <= '0;
         bcd_out    <= '0;
         dig_sel    <= SEL_OFF;
         dp_n       <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         cnt <= slot_end ? '0 : cnt + CW'(1);
         if (slot_end)
            idx <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
         if (frame_end) begin
            shadow <= bcd_in;
            shdp   <= dp_in;
         end
         bcd_out    <= cur_bcd;
         dp_n       <= ~cur_dp;
         dig_sel    <= sel_act ^ SEL_OFF;
         frame_tick <= frame_end;
      end
   end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux: directed scenarios plus randomized inputs and resets,
// compared each cycle against a time-arithmetic reference model.
module tb_seg_scan_mux;

   localparam int DIGITS  = 4;
   localparam int CLK_DIV = 8;
   localparam int BLANK   = 2;
   localparam int FRAME   = DIGITS * CLK_DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bcd_in = '0;
   logic [3:0]  dp_in = '0;

   logic [3:0]  bcd_out, bcd_out0;
   logic [3:0]  dig_sel, dig_sel0;
   logic        dp_n, dp_n0;
   logic        frame_tick, frame_tick0;

   always #5 clk = ~clk;

   seg_scan_mux #(
      .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYC(BLANK), .SEL_ACT_LOW(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in),
      .bcd_out(bcd_out), .dig_sel(dig_sel), .dp_n(dp_n), .frame_tick(frame_tick)
   );

   seg_scan_mux #(
      .DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BLANK_CYC(0), .SEL_ACT_LOW(1'b1)
   ) dut0 (
      .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in),
      .bcd_out(bcd_out0), .dig_sel(dig_sel0), .dp_n(dp_n0), .frame_tick(frame_tick0)
   );

   int          checks = 0;
   int          errors = 0;
   int          t = 0;               // cycles since reset release (state time)
   logic [15:0] m_shadow = '0;
   logic [3:0]  m_shdp = '0;

   // Expected active-low select for state time tt, given the frame's latched digits.
   function automatic logic [3:0] exp_sel(input int tt, input int blank,
                                          input logic [15:0] sh, input logic [3:0] dp);
      int         dig   = (tt / CLK_DIV) % DIGITS;
      int         pos   = tt % CLK_DIV;
      bit         shown = (pos >= blank);
      logic [3:0] s     = 4'b1111;
`ifdef SEG_SCAN_LZ_BLANK_EN
      if (dig > 0 && (sh >> (4*dig)) == 16'h0 && (dp >> dig) == 4'h0)
         shown = 1'b0;
`endif
      if (shown)
         s[dig] = 1'b0;
      return s;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, expv);
      end
   endtask

   // One clock: predict outputs from the current model state, advance the model, then compare.
   task automatic step();
      logic [3:0] e_sel, e_sel0, e_bcd;
      logic       e_dpn, e_tick;
      int         dig;
      if (rst) begin
         e_sel = 4'b1111; e_sel0 = 4'b1111; e_bcd = 4'h0; e_dpn = 1'b1; e_tick = 1'b0;
         t = 0; m_shadow = '0; m_shdp = '0;
      end else begin
         dig    = (t / CLK_DIV) % DIGITS;
         e_bcd  = m_shadow[4*dig +: 4];
         e_dpn  = ~m_shdp[dig];
         e_sel  = exp_sel(t, BLANK, m_shadow, m_shdp);
         e_sel0 = exp_sel(t, 0, m_shadow, m_shdp);
         e_tick = ((t % FRAME) == FRAME - 1);
         if ((t % FRAME) == FRAME - 1) begin
            m_shadow = bcd_in;
            m_shdp   = dp_in;
         end
         t++;
      end
      @(posedge clk);
      #1;
      check("dig_sel", 32'(dig_sel), 32'(e_sel));
      check("bcd_out", 32'(bcd_out), 32'(e_bcd));
      check("dp_n", 32'(dp_n), 32'(e_dpn));
      check("frame_tick", 32'(frame_tick), 32'(e_tick));
      check("onehot_or_none", 32'($countones(~dig_sel) <= 1), 32'd1);
      check("dig_sel_noguard", 32'(dig_sel0), 32'(e_sel0));
      check("bcd_out_noguard", 32'(bcd_out0), 32'(e_bcd));
      check("dp_n_noguard", 32'(dp_n0), 32'(e_dpn));
      check("frame_tick_noguard", 32'(frame_tick0), 32'(e_tick));
   endtask

   initial begin
      logic [15:0] r;
      int          keep;

      // reset, then idle scan of zeros
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      bcd_in = 16'h1234;
      dp_in  = 4'b0100;
      repeat (45) step();

      // input change mid-frame must wait for the next frame load
      bcd_in = 16'h5678;
      repeat (30) step();

      // one-cycle reset mid-operation
      rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (2 * FRAME + 4) step();

      // leading-zero pattern
      bcd_in = 16'h0070;
      dp_in  = 4'b0000;
      repeat (2 * FRAME + 4) step();
      dp_in = 4'b0100;
      repeat (FRAME + 2) step();

      // randomized inputs, occasional leading zeros and resets
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(9) == 0) begin
            r      = 16'($urandom);
            keep   = $urandom_range(4);
            bcd_in = (keep == 4) ? r : (r & ((16'h1 << (4*keep)) - 16'h1));
            dp_in  = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
         end
         rst = ($urandom_range(149) == 0);
         step();
      end
      rst = 1'b0;
      repeat (FRAME + 2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
